// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller: pending/mask stage, lowest-index arbiter and a
// REQ/ACK/EOI handshake. Define INTR_EDGE_DETECT_EN for rising-edge sources; default is level.
module intr_ctrl #(
  parameter  int unsigned N_INTR     = 8,
  parameter  int unsigned ADDR_W     = 10,
  parameter  int unsigned VEC_BASE   = 860,
  parameter  int unsigned VEC_STRIDE = 20,
  localparam int unsigned ID_W       = (N_INTR > 1) ? $clog2(N_INTR) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_INTR-1:0] intr_in,
  input  logic              mask_we,
  input  logic [N_INTR-1:0] mask_in,
  output logic [N_INTR-1:0] mask_out,
  output logic              intr_req,
  input  logic              intr_ack,
  input  logic              intr_eoi,
  output logic [ADDR_W-1:0] intr_dir_out,
  output logic [ID_W-1:0]   intr_id,
  output logic              busy
);

  localparam int unsigned VW = ADDR_W + ID_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [N_INTR-1:0]   intr_s_q;
  logic [N_INTR-1:0]   mask_q;
  logic [N_INTR-1:0]   pending;
  logic [N_INTR-1:0]   eligible;
  logic                win_any;
  logic [ID_W-1:0]     win_idx;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   dir_q, dir_d;

  // Wrap-around is intentional: the vector table may straddle the top of program memory.
  function automatic logic [ADDR_W-1:0] vec_of(input logic [ID_W-1:0] idx);
    logic [VW-1:0] full;
    full = VW'(VEC_BASE) + VW'(idx) * VW'(VEC_STRIDE);
    return full[ADDR_W-1:0];
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      intr_s_q <= '0;
      mask_q   <= '1;
    end else begin
      intr_s_q <= intr_in;
      if (mask_we) mask_q <= mask_in;
    end
  end

`ifdef INTR_EDGE_DETECT_EN
  logic [N_INTR-1:0] pending_q, pending_d;
  logic [N_INTR-1:0] set_vec, clr_vec;

  // A fresh edge in the ack cycle must survive, so set is applied after clear.
  always_comb begin
    set_vec = intr_in & ~intr_s_q;
    clr_vec = '0;
    if (state_q == S_REQ && intr_ack) clr_vec = N_INTR'(1) << id_q;
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign pending = pending_q;
`else
  // Level sources: pending tracks the synchronised line; the peripheral clears it.
  assign pending = intr_s_q;
`endif

  assign eligible = pending & mask_q;

  // Descending scan so the lowest set index is the last (winning) assignment.
  always_comb begin
    win_idx = '0;
    win_any = |eligible;
    for (int i = N_INTR - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = ID_W'(i);
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    dir_d   = dir_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_any) begin
          state_d = S_REQ;
          id_d    = win_idx;
          dir_d   = vec_of(win_idx);
        end
      end
      S_REQ: begin
        if (intr_ack) state_d = S_SERVICE;
      end
      S_SERVICE: begin
        if (intr_eoi) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    req_d  = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      id_q    <= '0;
      dir_q   <= ADDR_W'(VEC_BASE);
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      id_q    <= id_d;
      dir_q   <= dir_d;
    end
  end

  assign mask_out     = mask_q;
  assign intr_req     = req_q;
  assign busy         = busy_q;
  assign intr_id      = id_q;
  assign intr_dir_out = dir_q;

endmodule
